// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetcher feeding decode from an in-order response FIFO.
// Latency: request accepted in cycle t with a 1-cycle memory -> instr_valid in cycle t+2 (no bypass).
// Backpressure: decode_ready low holds the head; issue stops once count + outstanding reaches DEPTH.
//
// Ports:
//   CLK, Reset              clock (rising edge) and asynchronous active-low reset
//   imem_req_valid/ready    fetch request handshake; imem_req_addr is the word-aligned fetch PC
//   imem_rsp_valid/data     in-order instruction responses, one per accepted request
//   redirect, redirect_pc   EXE-stage taken branch/jump: flush queue, restart fetch at redirect_pc
//   instr_valid/instr/pc    FIFO head presented to decode; decode_ready pops it
//   occupancy               number of valid FIFO entries (debug)
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,             // power of 2, >= 2
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     Reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     decode_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // DEPTH in counter width, and one bit wider for the credit sum.
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q, fetch_pc_d;   // next address to request
  logic [31:0]   rsp_pc_q,   rsp_pc_d;     // PC of the next response to be kept
  logic [CW-1:0] count_q,    count_d;      // valid FIFO entries
  logic [CW-1:0] outst_q,    outst_d;      // accepted requests not yet answered
  logic [CW-1:0] drop_q,     drop_d;       // stale responses still to be discarded
  logic [AW-1:0] head_q,     head_d;
  logic [AW-1:0] tail_q,     tail_d;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic [CW:0] credit_sum;
  logic        req_hs;
  logic        rsp_keep;
  logic        do_push;
  logic        do_pop;

  // Outstanding requests plus buffered entries must never exceed DEPTH,
  // which reserves a FIFO slot for every response in flight.
  assign credit_sum = {1'b0, count_q} + {1'b0, outst_q};

  // Reset gates the request combinationally so nothing is offered while
  // the memory (which shares Reset) is itself held in reset.
  assign imem_req_valid = Reset && !redirect && (credit_sum < DEPTH_EXT);
  assign imem_req_addr  = fetch_pc_q;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);
  // A response landing in the redirect cycle belongs to the old path.
  assign do_push  = rsp_keep && !redirect;
  assign do_pop   = instr_valid && decode_ready && !redirect;

  // ---------------------------------------------------------------------------
  // Outputs: head of the FIFO, forced to zero while empty so reset and
  // flush present clean values rather than stale storage.
  // ---------------------------------------------------------------------------
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? dat_mem[head_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[head_q]  : 32'h0;
  assign occupancy   = count_q;

  // Low address bits of a redirect target are meaningless for word fetch.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;

    // Outstanding tracks the memory regardless of redirect: every accepted
    // request still produces exactly one response.
    outst_d = outst_q + CW'(req_hs) - CW'(imem_rsp_valid);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      // Everything still in flight is stale. outst_q already counts any
      // responses left over from an earlier redirect, so this also covers
      // a redirect arriving during a drop phase.
      drop_d     = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          tail_d   = tail_q + AW'(1);
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      if (do_pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_q <= RESET_PC_ALIGNED;
      rsp_pc_q   <= RESET_PC_ALIGNED;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: contents are only meaningful below count_q, so no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (do_push) begin
      pc_mem[tail_q]  <= rsp_pc_q;
      dat_mem[tail_q] <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  // count + outstanding <= DEPTH means a response always finds a free slot.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!Reset)
    imem_rsp_valid |-> (count_q != DEPTH_C));
  // Every response must answer an accepted request.
  a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (!Reset)
    imem_rsp_valid |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed scenarios plus randomized traffic against a queue-based model.
// Memory model answers each accepted request in order after a configurable latency.
// Expected instruction stream is the sequential PC run restarted at every redirect/reset.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [31:0]            imem_req_addr;
  logic                   imem_rsp_valid;
  logic [31:0]            imem_rsp_data;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   instr_valid;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   decode_ready;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK            (clk),
    .Reset          (Reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .decode_ready   (decode_ready),
    .occupancy      (occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  // Reference model state
  logic [31:0] mq_pc[$];      // buffered entries as decode should see them
  logic [31:0] mq_dat[$];
  logic [31:0] pend_addr[$];  // memory: accepted, unanswered requests
  int          pend_due[$];
  int          drop_m;
  logic [31:0] fetch_m;
  logic [31:0] rsp_m;
  logic [31:0] stream_pc;
  logic [31:0] popped[$];
  int          first_hs;
  int          first_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Called just after a rising edge; asserts reset mid-cycle and releases it
  // two edges later, leaving the model in its post-reset state.
  task automatic do_reset();
    Reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    decode_ready   = 1'b0;
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    mq_pc.delete(); mq_dat.delete();
    pend_addr.delete(); pend_due.delete();
    drop_m    = 0;
    fetch_m   = RESET_PC;
    rsp_m     = RESET_PC;
    stream_pc = RESET_PC;
    first_hs  = -1;
    first_vld = -1;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("post_rst_req_valid", imem_req_valid, 1);
    chk("post_rst_addr", imem_req_addr, RESET_PC);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic rdy, input logic dec, input logic rd, input logic [31:0] tgt);
    logic        rsp_now;
    logic [31:0] rsp_dat;
    logic        ev, er, hs, pop;
    rsp_now = 1'b0;
    rsp_dat = $urandom;
    if (pend_addr.size() > 0) begin
      if (pend_due[0] <= cyc) begin
        rsp_now = 1'b1;
        rsp_dat = mem_word(pend_addr[0]);
      end
    end
    imem_req_ready = rdy;
    decode_ready   = dec;
    redirect       = rd;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_dat;

    @(negedge clk);
    ev = (mq_pc.size() != 0);
    chk("instr_valid", instr_valid, ev);
    chk("occupancy", occupancy, mq_pc.size());
    if (ev) begin
      chk("instr_pc", instr_pc, mq_pc[0]);
      chk("instr", instr, mq_dat[0]);
    end
    er = !rd && (mq_pc.size() + pend_addr.size() < DEPTH);
    chk("req_valid", imem_req_valid, er);
    if (er) chk("req_addr", imem_req_addr, fetch_m);

    hs  = imem_req_valid && rdy;
    pop = ev && dec && !rd;
    if (hs && first_hs < 0) first_hs = cyc;
    if (instr_valid && first_vld < 0) first_vld = cyc;

    if (pop) begin
      chk("stream_pc", instr_pc, stream_pc);
      chk("stream_dat", instr, mem_word(stream_pc));
      popped.push_back(instr_pc);
      stream_pc += 32'd4;
    end

    if (rd) begin
      mq_pc.delete(); mq_dat.delete();
      drop_m    = pend_addr.size() - (rsp_now ? 1 : 0);
      fetch_m   = {tgt[31:2], 2'b00};
      rsp_m     = fetch_m;
      stream_pc = fetch_m;
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_dat.pop_front());
      end
      if (rsp_now) begin
        if (drop_m > 0) drop_m--;
        else begin
          mq_pc.push_back(rsp_m);
          mq_dat.push_back(rsp_dat);
          rsp_m += 32'd4;
        end
      end
      if (hs) fetch_m += 32'd4;
    end

    if (rsp_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (hs) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int n;
    logic        rdy, dec, rd;
    logic [31:0] tgt;

    // 1: first fetch latency and in-order delivery 0,4,8,C
    lat = 1;
    do_reset();
    popped.delete();
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p1_latency", first_vld - first_hs, 2);
    chk("p1_npops", popped.size() >= 4, 1);
    if (popped.size() >= 4)
      for (int i = 0; i < 4; i++) chk("p1_pc", popped[i], 32'(4 * i));

    // 2: decode stall fills the queue, then drains without gaps
    do_reset();
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("p2_occupancy", occupancy, DEPTH);
    chk("p2_req_valid", imem_req_valid, 0);
    chk("p2_head_pc", instr_pc, 32'h0);
    popped.delete();
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p2_npops", popped.size() >= 8, 1);
    if (popped.size() >= 8)
      for (int i = 0; i < 8; i++) chk("p2_pc", popped[i], 32'(4 * i));

    // 3: memory not ready holds the address at 0x10
    do_reset();
    popped.delete();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p3_addr_before", imem_req_addr, 32'h10);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("p3_addr_held", imem_req_addr, 32'h10);
    chk("p3_req_valid", imem_req_valid, 1);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p3_npops", popped.size() >= 5, 1);
    if (popped.size() >= 5) chk("p3_pc_after_hold", popped[4], 32'h10);

    // 4: 3-cycle memory, redirect with 3 outstanding
    lat = 3;
    do_reset();
    n = 0;
    while (pend_addr.size() != 3 && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("p4_reach_3_outstanding", pend_addr.size() == 3, 1);
    popped.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p4_npops", popped.size() >= 2, 1);
    if (popped.size() >= 2) begin
      chk("p4_first_pc", popped[0], 32'h200);
      chk("p4_second_pc", popped[1], 32'h204);
    end

    // 5: redirect coinciding with a response and a pop-eligible head
    lat = 1;
    do_reset();
    n = 0;
    while (!(mq_pc.size() > 0 && pend_addr.size() > 0 && pend_due[0] <= cyc) && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("p5_setup", mq_pc.size() > 0, 1);
    cycle(1'b1, 1'b1, 1'b1, 32'h43);
    chk("p5_occupancy", occupancy, 0);
    chk("p5_instr_valid", instr_valid, 0);
    chk("p5_restart_addr", imem_req_addr, 32'h40);
    popped.delete();
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p5_npops", popped.size() >= 1, 1);
    if (popped.size() >= 1) chk("p5_first_pc", popped[0], 32'h40);

    // 6: back-to-back redirects with 2 outstanding
    lat = 3;
    do_reset();
    n = 0;
    while (pend_addr.size() != 2 && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("p6_reach_2_outstanding", pend_addr.size() == 2, 1);
    popped.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b1, 1'b1, 32'h300);
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("p6_npops", popped.size() >= 1, 1);
    if (popped.size() >= 1) chk("p6_first_pc", popped[0], 32'h300);

    // 7: randomized traffic, latency, stalls, redirects and resets
    do_reset();
    for (int blk = 0; blk < 60; blk++) begin
      int pr, pd;
      lat = $urandom_range(1, 4);
      pr  = $urandom_range(30, 100);
      pd  = $urandom_range(20, 100);
      if (blk % 15 == 7) do_reset();
      for (int k = 0; k < 50; k++) begin
        rdy = ($urandom_range(0, 99) < pr);
        dec = ($urandom_range(0, 99) < pd);
        rd  = ($urandom_range(0, 99) < 4);
        tgt = $urandom;
        if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        cycle(rdy, dec, rd, tgt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
